source_fill: RTL

Command-driven waveform loader that sits directly upstream of the per-channel PCM source memory. It generates one burst pattern per command (constant, ramp or square) and writes it into the selected channel's memory as packed 32-bit words over the clk_2 register bus. It also owns the per-channel `signal_len` vector that enables playback. Playback of a channel is disabled while that channel is being refilled, then re-enabled with the new length.

---
 rtl/source_fill.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/source_fill.sv
// source_fill: command-driven PCM pattern loader.
// Writes constant/ramp/square bursts as packed sample pairs per channel.
module source_fill #(
  parameter int CHANNEL = 3,
  parameter int pcmaw   = 10,
  parameter int TMO     = 16
) (
  input  logic                       clk_2,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [3:0]                 cmd_chan,
  input  logic [pcmaw-1:0]           cmd_len,
  input  logic [1:0]                 cmd_mode,
  input  logic [15:0]                cmd_start,
  input  logic [15:0]                cmd_step,
  output logic [15:0]                reg_addr,
  output logic                       reg_wr,
  output logic [31:0]                reg_writedata,
  input  logic                       reg_ready,
  output logic [pcmaw*CHANNEL-1:0]   signal_len,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  typedef enum logic [2:0] {
    IDLE, CLR, WR, GAP, FIN
  } state_t;

  localparam int TW = $clog2(TMO + 1);
  localparam logic [TW-1:0] TLAST = TW'(TMO - 1);
  localparam logic [TW-1:0] TONE = TW'(1);
  localparam logic [pcmaw-1:0] WONE = pcmaw'(1);

  state_t state, nxt;

  logic [3:0]       chan;
  logic [1:0]       mode;
  logic [15:0]      start, step;
  logic [pcmaw-1:0] len_l, w, half;
  logic [15:0]      acc, hc;
  logic             neg;
  logic [TW-1:0]    tcnt;

  logic accept, bad, load, time_up;
  logic [15:0] hp, neg_st, s0, s1, hc_a, hc_b;
  logic neg_a, neg_b;

  assign cmd_ready = (state == IDLE);
  assign busy = (state != IDLE);
  assign accept = cmd_valid & cmd_ready;
  assign bad = (32'(cmd_chan) >= CHANNEL)
             | (cmd_mode == 2'd3);
  assign half = {1'b0, len_l[pcmaw-1:1]};
  assign time_up = (tcnt == TLAST);

  always_comb begin
    nxt = state;
    load = 1'b0;
    unique case (state)
      IDLE: if (accept && !bad) nxt = CLR;
      CLR: begin
        if (len_l == '0) nxt = FIN;
        else begin
          nxt = WR;
          load = 1'b1;
        end
      end
      WR: begin
        if (reg_ready) nxt = GAP;
        else if (time_up) nxt = IDLE;
      end
      GAP: begin
        if (w == half) nxt = FIN;
        else begin
          nxt = WR;
          load = 1'b1;
        end
      end
      FIN: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Two samples per word; square phase advances once per sample.
  always_comb begin
    hp = (step == 16'd0) ? 16'd1 : step;
    neg_st = 16'd0 - start;
    hc_a = hc + 16'd1;
    neg_a = neg;
    if (hc_a == hp) begin
      hc_a = 16'd0;
      neg_a = ~neg;
    end
    hc_b = hc_a + 16'd1;
    neg_b = neg_a;
    if (hc_b == hp) begin
      hc_b = 16'd0;
      neg_b = ~neg_a;
    end
    s0 = start;
    s1 = start;
    if (mode == 2'd1) begin
      s0 = acc;
      s1 = acc + step;
    end else if (mode == 2'd2) begin
      s0 = neg ? neg_st : start;
      s1 = neg_a ? neg_st : start;
    end
  end

  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      chan <= '0;
      mode <= '0;
      start <= '0;
      step <= '0;
      len_l <= '0;
      w <= '0;
      acc <= '0;
      hc <= '0;
      neg <= 1'b0;
      tcnt <= '0;
      reg_wr <= 1'b0;
      reg_addr <= '0;
      reg_writedata <= '0;
      signal_len <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      done <= 1'b0;
      err <= 1'b0;
      if (accept) begin
        chan <= cmd_chan;
        mode <= cmd_mode;
        start <= cmd_start;
        step <= cmd_step;
        len_l <= {cmd_len[pcmaw-1:1], 1'b0};
        acc <= cmd_start;
        hc <= '0;
        neg <= 1'b0;
        w <= '0;
        err <= bad;
      end
      if (load) begin
        reg_wr <= 1'b1;
        reg_addr <= {chan, 12'(w)};
        reg_writedata <= {s1, s0};
        acc <= acc + {step[14:0], 1'b0};
        hc <= hc_b;
        neg <= neg_b;
        tcnt <= '0;
      end
      if (state == WR) begin
        if (reg_ready) begin
          reg_wr <= 1'b0;
          w <= w + WONE;
        end else if (time_up) begin
          reg_wr <= 1'b0;
          err <= 1'b1;
        end else begin
          tcnt <= tcnt + TONE;
        end
      end
      if (state == FIN) done <= 1'b1;
      for (int k = 0; k < CHANNEL; k++) begin
        if (chan == 4'(k)) begin
          if (state == CLR)
            signal_len[k*pcmaw +: pcmaw] <= '0;
          if (state == FIN && len_l != '0)
            signal_len[k*pcmaw +: pcmaw] <= len_l;
        end
      end
    end
  end

endmodule
